// File: rtl/valve_step_sequencer_pkg.sv
// +--------------------------------------------------------------------------+
// | valve_step_sequencer_pkg : unit codes, FSM encoding, step-entry helpers  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package valve_step_sequencer_pkg;

  localparam int UNIT_W = 3;
  typedef logic [UNIT_W-1:0] unit_t;

  localparam unit_t UNIT_MS   = 3'b001;
  localparam unit_t UNIT_S    = 3'b010;
  localparam unit_t UNIT_MIN  = 3'b011;
  localparam unit_t UNIT_HOUR = 3'b100;
  localparam unit_t UNIT_DAY  = 3'b101;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD   = 3'd1;
  localparam logic [STATE_W-1:0] ST_CLEAR  = 3'd2;
  localparam logic [STATE_W-1:0] ST_ARM    = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT   = 3'd4;
  localparam logic [STATE_W-1:0] ST_NEXT   = 3'd5;
  localparam logic [STATE_W-1:0] ST_FINISH = 3'd6;
  localparam logic [STATE_W-1:0] ST_ABORT  = 3'd7;

  // Step entry is packed MSB-first as {last, unit, delay, valves}.
  function automatic int entry_width(input int valve_w, input int delay_w);
    return 1 + UNIT_W + delay_w + valve_w;
  endfunction

  function automatic logic unit_valid(input unit_t unit);
    return (unit >= UNIT_MS) && (unit <= UNIT_DAY);
  endfunction

endpackage

`default_nettype wire

// File: rtl/valve_step_sequencer_sync_2ff.sv
// +--------------------------------------------------------------------------+
// | sync_2ff : generic two-flop synchronizer with asynchronous reset        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/valve_step_sequencer.sv
// +--------------------------------------------------------------------------+
// | valve_step_sequencer : steps a valve table, arming a delay counter each |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module valve_step_sequencer
  import valve_step_sequencer_pkg::*;
#(
  parameter int NUM_STEPS  = 16,
  parameter int VALVE_W    = 8,
  parameter int DELAY_W    = 10,
  parameter int CLR_CYCLES = 2000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         prog_we,
  input  logic [$clog2(NUM_STEPS)-1:0] prog_addr,
  input  logic [VALVE_W-1:0]           prog_valves,
  input  logic [DELAY_W-1:0]           prog_delay,
  input  logic [2:0]                   prog_unit,
  input  logic                         prog_last,
  input  logic                         run,
  input  logic                         abort,
  output logic                         delay_clr,
  output logic                         delay_start,
  output logic [DELAY_W-1:0]           delay_val,
  output logic [2:0]                   delay_unit,
  input  logic                         delay_done,
  output logic [VALVE_W-1:0]           valves,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic                         busy,
  output logic                         seq_done,
  output logic                         err
);

  localparam int                 IDX_W     = $clog2(NUM_STEPS);
  localparam int                 HOLD_W    = 22;
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_STEPS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(CLR_CYCLES - 1);
  localparam int                 ENTRY_W   = entry_width(VALVE_W, DELAY_W);

  typedef struct packed {
    logic                last;
    unit_t               unit;
    logic [DELAY_W-1:0]  delay;
    logic [VALVE_W-1:0]  valves;
  } step_t;

  step_t                r_table [NUM_STEPS];
  step_t                w_entry;
  logic [STATE_W-1:0]   r_state;
  logic [STATE_W-1:0]   w_state_nxt;
  logic [HOLD_W-1:0]    r_hold;
  logic                 w_hold_ok;
  logic                 w_done_s;
  logic                 w_abort_now;
  logic [IDX_W-1:0]     r_idx;
  logic [VALVE_W-1:0]   r_valves;
  logic [DELAY_W-1:0]   r_delay_val;
  logic [2:0]           r_delay_unit;
  logic                 r_delay_clr;
  logic                 r_delay_start;
  logic                 r_busy;
  logic                 r_seq_done;
  logic                 r_err;

  sync_2ff #(.WIDTH(1)) u_done_sync (
    .clk (clk),
    .rst (rst),
    .d   (delay_done),
    .q   (w_done_s)
  );

  assign w_entry     = r_table[r_idx];
  assign w_hold_ok   = (r_hold >= HOLD_LAST);
  assign w_abort_now = abort && (r_state != ST_IDLE) && (r_state != ST_ABORT);

  // Table content is deliberately not reset; only IDLE writes are honoured.
  always_ff @(posedge clk) begin
    if (prog_we && (r_state == ST_IDLE)) begin
      r_table[prog_addr] <= step_t'({prog_last, prog_unit, prog_delay, prog_valves});
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (run && !abort) w_state_nxt = ST_LOAD;
      ST_LOAD:   w_state_nxt = unit_valid(w_entry.unit) ? ST_CLEAR : ST_FINISH;
      ST_CLEAR:  if (w_hold_ok && !w_done_s)
                   w_state_nxt = (r_delay_val == '0) ? ST_NEXT : ST_ARM;
      ST_ARM:    w_state_nxt = ST_WAIT;
      ST_WAIT:   if (w_done_s) w_state_nxt = ST_NEXT;
      ST_NEXT:   w_state_nxt = (w_entry.last || (r_idx == IDX_LAST)) ? ST_FINISH : ST_LOAD;
      ST_FINISH: w_state_nxt = ST_IDLE;
      ST_ABORT:  if (w_hold_ok) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_abort_now) w_state_nxt = ST_ABORT;
  end

  // Strobe-style outputs are registered from the next state so they are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_hold        <= '0;
      r_idx         <= '0;
      r_valves      <= '0;
      r_delay_val   <= '0;
      r_delay_unit  <= '0;
      r_delay_clr   <= 1'b0;
      r_delay_start <= 1'b0;
      r_busy        <= 1'b0;
      r_seq_done    <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_delay_clr   <= (w_state_nxt == ST_CLEAR) || (w_state_nxt == ST_ABORT);
      r_delay_start <= (w_state_nxt == ST_ARM);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_seq_done    <= (r_state == ST_NEXT) && (w_state_nxt == ST_FINISH);

      if (w_state_nxt != r_state) begin
        r_hold <= '0;
      end else if (r_hold != '1) begin
        r_hold <= r_hold + HOLD_W'(1);
      end

      if (w_abort_now) begin
        r_valves <= '0;
        r_idx    <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (abort) begin
              r_valves <= '0;
            end else if (run) begin
              r_idx <= '0;
              r_err <= 1'b0;
            end
          end
          ST_LOAD: begin
            r_delay_val  <= w_entry.delay;
            r_delay_unit <= w_entry.unit;
            if (unit_valid(w_entry.unit)) begin
              r_valves <= w_entry.valves;
            end else begin
              r_valves <= '0;
              r_err    <= 1'b1;
            end
          end
          ST_NEXT: if (w_state_nxt == ST_LOAD) r_idx <= r_idx + IDX_W'(1);
          default: ;
        endcase
      end
    end
  end

  assign delay_clr   = r_delay_clr;
  assign delay_start = r_delay_start;
  assign delay_val   = r_delay_val;
  assign delay_unit  = r_delay_unit;
  assign valves      = r_valves;
  assign step_idx    = r_idx;
  assign busy        = r_busy;
  assign seq_done    = r_seq_done;
  assign err         = r_err;

  if (ENTRY_W != $bits(step_t)) begin : g_entry_width_mismatch
    $error("step entry layout width mismatch");
  end

endmodule

`default_nettype wire

// File: tb/tb_valve_step_sequencer.sv
// Bench for valve_step_sequencer: vector table, corner sequences and a
// randomized program checked against a step-level reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_valve_step_sequencer;

  localparam int CLR = 4;

  typedef struct packed {
    logic       last;
    logic [2:0] unit;
    logic [9:0] delay;
    logic [7:0] valves;
  } step_t;

  typedef struct packed {
    logic [7:0] valves;
    logic [9:0] dval;
    logic [2:0] unit;
  } ev_t;

  typedef struct {
    logic [7:0] v;
    logic [9:0] d;
    logic [2:0] u;
    int         starts;
    int         seq;
    logic       e;
    logic [7:0] fin;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_valves = '0;
  logic [9:0] prog_delay = '0;
  logic [2:0] prog_unit = '0;
  logic       prog_last = 1'b0;
  logic       run = 1'b0;
  logic       abort = 1'b0;
  logic       delay_done = 1'b0;
  logic       delay_clr, delay_start, busy, seq_done, err;
  logic [9:0] delay_val;
  logic [2:0] delay_unit;
  logic [7:0] valves;
  logic [3:0] step_idx;

  valve_step_sequencer #(
    .NUM_STEPS(16), .VALVE_W(8), .DELAY_W(10), .CLR_CYCLES(CLR)
  ) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_valves(prog_valves), .prog_delay(prog_delay), .prog_unit(prog_unit),
    .prog_last(prog_last), .run(run), .abort(abort), .delay_clr(delay_clr),
    .delay_start(delay_start), .delay_val(delay_val), .delay_unit(delay_unit),
    .delay_done(delay_done), .valves(valves), .step_idx(step_idx), .busy(busy),
    .seq_done(seq_done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Delay counter model: done rises done_lat cycles after the arm pulse, drops while cleared.
  int done_lat = 20;
  bit stuck = 0;
  bit armed = 0;
  int left = 0;
  always @(negedge clk) begin
    if (stuck) delay_done = 1'b1;
    else if (delay_clr) begin delay_done = 1'b0; armed = 0; end
    else if (delay_start) begin armed = 1; left = done_lat; end
    else if (armed) begin
      left--;
      if (left <= 0) begin delay_done = 1'b1; armed = 0; end
    end
  end

  // Event monitor.
  ev_t q_start[$];
  int  clr_run = 0, clr_last = 0, short_clr = 0, seq_cnt = 0;
  int  cyc = 0, seq_cyc = -10, fall_cyc = -20;
  bit  busy_q = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (delay_clr) clr_run++;
      else if (clr_run != 0) begin clr_last = clr_run; clr_run = 0; end
      if (delay_start) begin
        q_start.push_back({valves, delay_val, delay_unit});
        if (clr_last < CLR) short_clr++;
      end
      if (seq_done) begin seq_cnt++; seq_cyc = cyc; end
      if (busy_q && !busy) fall_cyc = cyc;
      busy_q = busy;
    end
    cyc++;
  end

  task automatic clear_mon();
    q_start.delete();
    short_clr = 0; seq_cnt = 0; seq_cyc = -10; fall_cyc = -20;
  endtask

  // Reference model over the bench's own copy of the table.
  step_t      mtab [16];
  ev_t        exp_q[$];
  int         exp_seq;
  logic       exp_err;
  logic [7:0] exp_final;

  function automatic void model_run();
    exp_q.delete();
    exp_seq = 0; exp_err = 1'b0; exp_final = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (mtab[i].unit < 3'd1 || mtab[i].unit > 3'd5) begin
        exp_err = 1'b1; exp_final = 8'h00;
        return;
      end
      exp_final = mtab[i].valves;
      if (mtab[i].delay != 10'd0) exp_q.push_back({mtab[i].valves, mtab[i].delay, mtab[i].unit});
      if (mtab[i].last || i == 15) begin exp_seq = 1; return; end
    end
  endfunction

  function automatic step_t mk(input logic [7:0] v, input logic [9:0] d,
                               input logic [2:0] u, input logic l);
    step_t s;
    s.last = l; s.unit = u; s.delay = d; s.valves = v;
    return s;
  endfunction

  task automatic prog(input int a, input step_t e, input bit upd);
    prog_we = 1'b1; prog_addr = 4'(a);
    prog_valves = e.valves; prog_delay = e.delay; prog_unit = e.unit; prog_last = e.last;
    @(negedge clk);
    prog_we = 1'b0;
    if (upd) mtab[a] = e;
  endtask

  task automatic do_run(input bit busy_write);
    int t;
    clear_mon();
    run = 1'b1; @(negedge clk); run = 1'b0;
    if (busy_write) prog(0, mk(8'h99, 10'd0, 3'b111, 1'b1), 0);
    t = 0;
    while (busy && t < 3000) begin @(negedge clk); t++; end
    chk("run_timeout_busy", busy, 0);
    @(negedge clk);
  endtask

  task automatic compare_run(input string tag);
    chk($sformatf("%s starts", tag), q_start.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q_start.size(); i++)
      chk($sformatf("%s start_ev%0d", tag, i), 32'(q_start[i]), 32'(exp_q[i]));
    chk($sformatf("%s seq_done", tag), seq_cnt, exp_seq);
    chk($sformatf("%s err", tag), err, exp_err);
    chk($sformatf("%s valves", tag), valves, exp_final);
    chk($sformatf("%s clr_hold", tag), short_clr, 0);
    if (exp_seq == 1) chk($sformatf("%s busy_fall", tag), fall_cyc - seq_cyc, 1);
  endtask

  vec_t vecs[6];

  initial begin
    int t, n, k;
    step_t s;

    vecs[0] = '{v:8'h0F, d:10'd3,   u:3'b001, starts:1, seq:1, e:1'b0, fin:8'h0F};
    vecs[1] = '{v:8'hA5, d:10'd0,   u:3'b010, starts:0, seq:1, e:1'b0, fin:8'hA5};
    vecs[2] = '{v:8'h3C, d:10'd7,   u:3'b000, starts:0, seq:0, e:1'b1, fin:8'h00};
    vecs[3] = '{v:8'hFF, d:10'd1,   u:3'b101, starts:1, seq:1, e:1'b0, fin:8'hFF};
    vecs[4] = '{v:8'h81, d:10'd2,   u:3'b110, starts:0, seq:0, e:1'b1, fin:8'h00};
    vecs[5] = '{v:8'h55, d:10'd1023,u:3'b100, starts:1, seq:1, e:1'b0, fin:8'h55};

    repeat (3) @(negedge clk);
    chk("reset valves", valves, 0);
    chk("reset strobes", {delay_clr, delay_start, busy, seq_done, err}, 0);
    chk("reset idx_delay", {step_idx, delay_val, delay_unit}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single-step vector table.
    done_lat = 6;
    for (int i = 0; i < 6; i++) begin
      prog(0, mk(vecs[i].v, vecs[i].d, vecs[i].u, 1'b1), 1);
      do_run(0);
      chk($sformatf("vec%0d starts", i), q_start.size(), vecs[i].starts);
      chk($sformatf("vec%0d seq_done", i), seq_cnt, vecs[i].seq);
      chk($sformatf("vec%0d err", i), err, vecs[i].e);
      chk($sformatf("vec%0d valves", i), valves, vecs[i].fin);
      if (vecs[i].starts == 1) chk($sformatf("vec%0d dval", i), q_start[0].dval, vecs[i].d);
    end

    // Two-step program, counter completes 20 cycles after arm.
    done_lat = 20;
    prog(0, mk(8'h0F, 10'd3, 3'b001, 1'b0), 1);
    prog(1, mk(8'hF0, 10'd5, 3'b010, 1'b1), 1);
    model_run();
    do_run(0);
    compare_run("two_step");
    if (q_start.size() == 2) begin
      chk("two_step v0", q_start[0].valves, 8'h0F);
      chk("two_step v1", q_start[1].valves, 8'hF0);
    end

    // Bad unit: err within two cycles, then cleared by the next run.
    prog(0, mk(8'h77, 10'd4, 3'b000, 1'b1), 1);
    clear_mon();
    run = 1'b1; @(negedge clk); run = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("badunit busy", busy, 0);
    chk("badunit err", err, 1);
    chk("badunit valves", valves, 0);
    @(negedge clk);
    chk("badunit seq_done", seq_cnt, 0);
    prog(0, mk(8'h21, 10'd0, 3'b011, 1'b1), 1);
    run = 1'b1; @(negedge clk); run = 1'b0;
    chk("rerun err_clear", err, 0);
    t = 0;
    while (busy && t < 500) begin @(negedge clk); t++; end
    chk("rerun idle", busy, 0);

    // Delay of zero: no arm, pattern held at least five cycles.
    prog(0, mk(8'hC3, 10'd0, 3'b001, 1'b1), 1);
    clear_mon();
    run = 1'b1; @(negedge clk); run = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (valves == 8'hC3) n++; end
    chk("zero_delay visible", (n >= 5), 1);
    chk("zero_delay no_start", q_start.size(), 0);
    chk("zero_delay seq_done", seq_cnt, 1);

    // Abort in WAIT of step 1.
    prog(0, mk(8'h11, 10'd4, 3'b001, 1'b0), 1);
    prog(1, mk(8'h22, 10'd4, 3'b010, 1'b0), 1);
    prog(2, mk(8'h33, 10'd4, 3'b011, 1'b1), 1);
    clear_mon();
    run = 1'b1; @(negedge clk); run = 1'b0;
    t = 0;
    while (!(delay_start && step_idx == 4'd1) && t < 500) begin @(negedge clk); t++; end
    chk("abort reach_step1", (t < 500), 1);
    repeat (3) @(negedge clk);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort valves", valves, 0);
    chk("abort idx", step_idx, 0);
    n = delay_clr ? 1 : 0;
    t = 0;
    while (delay_clr && t < 50) begin @(negedge clk); t++; if (delay_clr) n++; end
    chk("abort clr_cycles", n, CLR);
    chk("abort idle", busy, 0);
    chk("abort seq_done", seq_cnt, 0);
    chk("abort err", err, 0);

    // delay_done stuck high while entering CLEAR.
    prog(0, mk(8'h5A, 10'd5, 3'b001, 1'b1), 1);
    stuck = 1; delay_done = 1'b1; done_lat = 8;
    clear_mon();
    run = 1'b1; @(negedge clk); run = 1'b0;
    repeat (15) @(negedge clk);
    chk("stuck no_start", q_start.size(), 0);
    chk("stuck in_clear", {busy, delay_clr}, 2'b11);
    stuck = 0;
    t = 0;
    while (busy && t < 500) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("stuck one_start", q_start.size(), 1);
    chk("stuck seq_done", seq_cnt, 1);

    // Write while busy is ignored; rerun reproduces original pattern.
    prog(0, mk(8'h0F, 10'd3, 3'b001, 1'b0), 1);
    prog(1, mk(8'hF0, 10'd5, 3'b010, 1'b1), 1);
    model_run();
    do_run(1);
    compare_run("busy_write_run1");
    do_run(0);
    compare_run("busy_write_run2");

    // Abort in IDLE drops the held pattern only.
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("idle_abort valves", valves, 0);
    chk("idle_abort busy", busy, 0);

    // All sixteen steps without a last flag end at the final index.
    done_lat = 3;
    for (int i = 0; i < 16; i++)
      prog(i, mk(8'(i * 17 + 1), (i % 5 == 0) ? 10'd2 : 10'd0, 3'(1 + i % 5), 1'b0), 1);
    model_run();
    do_run(0);
    compare_run("full_table");
    chk("full_table idx", step_idx, 4'd15);

    // Randomized programs.
    for (int r = 0; r < 20; r++) begin
      k = $urandom_range(0, 3);
      for (int i = 0; i <= k; i++) begin
        s.valves = 8'($urandom);
        s.delay  = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
        s.unit   = ($urandom_range(0, 9) != 0) ? 3'($urandom_range(1, 5)) : 3'($urandom_range(0, 7));
        s.last   = (i == k);
        prog(i, s, 1);
      end
      done_lat = $urandom_range(1, 12);
      model_run();
      do_run(0);
      compare_run($sformatf("rand%0d", r));
    end

    // Asynchronous reset mid-sequence.
    prog(0, mk(8'h0F, 10'd3, 3'b001, 1'b0), 1);
    prog(1, mk(8'hF0, 10'd5, 3'b010, 1'b1), 1);
    run = 1'b1; @(negedge clk); run = 1'b0;
    t = 0;
    while (!delay_start && t < 500) begin @(negedge clk); t++; end
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("midrst valves", valves, 0);
    chk("midrst strobes", {busy, delay_clr, delay_start}, 0);
    chk("midrst idx", step_idx, 0);
    @(negedge clk); rst = 1'b0; @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
